// File: rtl/seq_pkg.sv
// Shared types for the serial detector / pattern generator pair: detector and
// generator state encodings plus the detector next-state function.
package seq_pkg;

  typedef enum logic [2:0] {
    DET_A = 3'd0,
    DET_B = 3'd1,
    DET_C = 3'd2,
    DET_D = 3'd3,
    DET_E = 3'd4,
    DET_F = 3'd5
  } det_state_e;

  typedef enum logic [1:0] {
    GEN_IDLE  = 2'd0,
    GEN_SHIFT = 2'd1,
    GEN_GAP   = 2'd2
  } gen_state_e;

  function automatic det_state_e det_next(input det_state_e s, input logic w);
    det_state_e n;
    case (s)
      DET_A:   n = w ? DET_B : DET_A;
      DET_B:   n = w ? DET_C : DET_E;
      DET_C:   n = w ? DET_C : DET_D;
      DET_D:   n = w ? DET_F : DET_A;
      DET_E:   n = w ? DET_F : DET_A;
      DET_F:   n = w ? DET_C : DET_E;
      default: n = DET_A;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/det_model.sv
// Reference Moore model of the serial sequence detector; z is high in D and F.
// Reusable standalone by benches that need a predicted detector output.
module det_model
  import seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic w,
  output logic z
);

  det_state_e state_q;
  det_state_e state_d;

  assign state_d = det_next(state_q, w);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= DET_D;
    else      state_q <= state_d;
  end

  assign z = (state_q == DET_D) || (state_q == DET_F);

endmodule

// File: rtl/serial_pattern_gen.sv
// Serialises handshaked pattern words MSB-first onto w, with optional idle gap.
// Define SERIAL_PATTERN_GEN_EXPECT_EN to embed the detector model driving z_exp.
module serial_pattern_gen
  import seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH):0]   in_len,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     w,
  output logic                     w_valid,
  output logic                     done,
  output logic                     busy,
  output logic                     z_exp
);

  localparam int              LW      = $clog2(WIDTH) + 1;
  localparam logic [LW-1:0]   WIDTH_L = LW'(WIDTH);
  localparam logic [LW-1:0]   ONE_L   = LW'(1);
  localparam logic [LW-1:0]   TWO_L   = LW'(2);
  localparam logic [3:0]      GAP_L   = 4'(GAP);

  gen_state_e       state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [LW-1:0]    cnt_q;
  logic [3:0]       gcnt_q;
  logic             w_q;
  logic             w_valid_q;
  logic             done_q;

  logic [LW-1:0]    eff_len_d;
  logic             last_bit;
  logic             accept;

  assign eff_len_d = (in_len == '0 || in_len > WIDTH_L) ? WIDTH_L : in_len;
  assign last_bit  = (state_q == GEN_SHIFT) && (cnt_q == ONE_L);
  // With no gap the next word may be taken while its predecessor's last bit is on w.
  assign in_ready  = (state_q == GEN_IDLE) || ((GAP == 0) && last_bit);
  assign accept    = in_valid && in_ready;

  // shreg_q holds only the bits still to be sent; the current bit lives in w_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= GEN_IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      gcnt_q    <= '0;
      w_q       <= 1'b0;
      w_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (accept) begin
      state_q   <= GEN_SHIFT;
      shreg_q   <= {in_data[WIDTH-2:0], 1'b0};
      cnt_q     <= eff_len_d;
      w_q       <= in_data[WIDTH-1];
      w_valid_q <= 1'b1;
      done_q    <= (eff_len_d == ONE_L);
    end else begin
      case (state_q)
        GEN_SHIFT: begin
          if (cnt_q > ONE_L) begin
            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            cnt_q   <= cnt_q - ONE_L;
            w_q     <= shreg_q[WIDTH-1];
            done_q  <= (cnt_q == TWO_L);
          end else begin
            shreg_q   <= '0;
            cnt_q     <= '0;
            w_q       <= 1'b0;
            w_valid_q <= 1'b0;
            done_q    <= 1'b0;
            if (GAP > 0) begin
              state_q <= GEN_GAP;
              gcnt_q  <= GAP_L;
            end else begin
              state_q <= GEN_IDLE;
            end
          end
        end
        GEN_GAP: begin
          if (gcnt_q <= 4'd1) begin
            state_q <= GEN_IDLE;
            gcnt_q  <= '0;
          end else begin
            gcnt_q  <= gcnt_q - 4'd1;
          end
        end
        default: state_q <= GEN_IDLE;
      endcase
    end
  end

  assign w       = w_q;
  assign w_valid = w_valid_q;
  assign done    = done_q;
  assign busy    = (state_q != GEN_IDLE);

`ifdef SERIAL_PATTERN_GEN_EXPECT_EN
  det_model u_det (
    .clk (clk),
    .rst (rst),
    .w   (w_q),
    .z   (z_exp)
  );
`else
  assign z_exp = 1'b0;
`endif

endmodule
